regfile_access_sequencer: RTL and testbench



---
 rtl/regfile_access_sequencer_if.sv | 30 +++
 rtl/regfile_access_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_regfile_access_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_access_sequencer_if.sv
// Request/response channel between the decode/datapath side and
// regfile_access_sequencer. The master drives requests and consumes
// responses; the slave is the sequencer.
interface regfile_access_sequencer_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 6
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr_a;
    logic [ADDR_W-1:0] req_addr_b;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data_a;
    logic [DATA_W-1:0] rsp_data_b;
    logic              rsp_err;

    modport master (
        output req_valid, req_op, req_addr_a, req_addr_b, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data_a, rsp_data_b, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr_a, req_addr_b, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data_a, rsp_data_b, rsp_err
    );
endinterface

// File: rtl/regfile_access_sequencer.sv
// Initiator-side sequencer for the RegisterFile port protocol. Each accepted
// request becomes one registered single-cycle register-file command; read
// data is captured READ_LAT cycles after the command and returned on a
// response channel that is held until the consumer takes it.
// Optional build macro RFSEQ_READBACK_VERIFY_EN: every write is followed by a
// readback of the same register, and a mismatch is reported on rsp_err.
module regfile_access_sequencer #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 6,
    parameter int READ_LAT = 1    // legal range 1..7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    regfile_access_sequencer_if.slave  bus,
    output logic                       busy,
    output logic [1:0]                 rf_control_signal,
    output logic [DATA_W-1:0]          rf_input_port_1,
    output logic [DATA_W-1:0]          rf_input_port_2,
    input  logic [DATA_W-1:0]          rf_output_latch_1,
    input  logic [DATA_W-1:0]          rf_output_latch_2
);

    typedef enum logic [1:0] {
        OP_ILLEGAL   = 2'b00,
        OP_RD_SINGLE = 2'b01,
        OP_RD_DUAL   = 2'b10,
        OP_WRITE     = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
`ifdef RFSEQ_READBACK_VERIFY_EN
        , S_VERIFY_ISSUE
        , S_VERIFY_WAIT
`endif
    } state_e;

    localparam logic [2:0] LAT_LOAD = 3'(READ_LAT - 1);

    // Addresses travel on the data-width ports and must never be sign-extended.
    function automatic logic [DATA_W-1:0] zext(input logic [ADDR_W-1:0] a);
        return {{(DATA_W - ADDR_W){1'b0}}, a};
    endfunction

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic [DATA_W-1:0] port1_q, port1_d;
    logic [DATA_W-1:0] port2_q, port2_d;
    logic [DATA_W-1:0] rsp_a_q, rsp_a_d;
    logic [DATA_W-1:0] rsp_b_q, rsp_b_d;
    logic              rsp_err_q, rsp_err_d;
`ifdef RFSEQ_READBACK_VERIFY_EN
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
`endif

    logic req_ready_w;

    // Ready only when idle and out of reset, so reset also blocks acceptance.
    assign req_ready_w    = (state_q == S_IDLE) && rst_n;
    assign bus.req_ready  = req_ready_w;
    assign bus.rsp_valid  = (state_q == S_RESP);
    assign bus.rsp_data_a = rsp_a_q;
    assign bus.rsp_data_b = rsp_b_q;
    assign bus.rsp_err    = rsp_err_q;
    assign busy           = (state_q != S_IDLE);

    assign rf_control_signal = ctrl_q;
    assign rf_input_port_1   = port1_q;
    assign rf_input_port_2   = port2_q;

    // Next-state and next-register values; the RF command defaults to idle so
    // it is presented for exactly one cycle.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned, which would infer a latch.
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        ctrl_d    = 2'b00;
        port1_d   = '0;
        port2_d   = '0;
        rsp_a_d   = rsp_a_q;
        rsp_b_d   = rsp_b_q;
        rsp_err_d = rsp_err_q;
`ifdef RFSEQ_READBACK_VERIFY_EN
        addr_d    = addr_q;
        wdata_d   = wdata_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_w) begin
                    op_d = op_e'(bus.req_op);
`ifdef RFSEQ_READBACK_VERIFY_EN
                    addr_d  = bus.req_addr_a;
                    wdata_d = bus.req_wdata;
`endif
                    if (op_e'(bus.req_op) == OP_ILLEGAL) begin
                        rsp_a_d   = '0;
                        rsp_b_d   = '0;
                        rsp_err_d = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        ctrl_d = bus.req_op;
                        if (op_e'(bus.req_op) == OP_WRITE) begin
                            port1_d = bus.req_wdata;
                            port2_d = zext(bus.req_addr_a);
                        end else begin
                            port1_d = zext(bus.req_addr_a);
                            port2_d = (op_e'(bus.req_op) == OP_RD_DUAL) ?
                                      zext(bus.req_addr_b) : '0;
                        end
                        state_d = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                if (op_q == OP_WRITE) begin
`ifdef RFSEQ_READBACK_VERIFY_EN
                    ctrl_d  = OP_RD_SINGLE;
                    port1_d = zext(addr_q);
                    state_d = S_VERIFY_ISSUE;
`else
                    rsp_a_d   = '0;
                    rsp_b_d   = '0;
                    rsp_err_d = 1'b0;
                    state_d   = S_RESP;
`endif
                end else begin
                    cnt_d   = LAT_LOAD;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    rsp_a_d   = rf_output_latch_1;
                    rsp_b_d   = (op_q == OP_RD_DUAL) ? rf_output_latch_2 : '0;
                    rsp_err_d = 1'b0;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

`ifdef RFSEQ_READBACK_VERIFY_EN
            S_VERIFY_ISSUE: begin
                cnt_d   = LAT_LOAD;
                state_d = S_VERIFY_WAIT;
            end

            S_VERIFY_WAIT: begin
                if (cnt_q == 3'd0) begin
                    rsp_a_d   = rf_output_latch_1;
                    rsp_b_d   = '0;
                    rsp_err_d = (rf_output_latch_1 != wdata_q);
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
`endif

            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation and clears
    // the RF command lines immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= OP_ILLEGAL;
            cnt_q     <= '0;
            ctrl_q    <= 2'b00;
            port1_q   <= '0;
            port2_q   <= '0;
            rsp_a_q   <= '0;
            rsp_b_q   <= '0;
            rsp_err_q <= 1'b0;
`ifdef RFSEQ_READBACK_VERIFY_EN
            addr_q    <= '0;
            wdata_q   <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values computed before this edge, independent of statement order.
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            port1_q   <= port1_d;
            port2_q   <= port2_d;
            rsp_a_q   <= rsp_a_d;
            rsp_b_q   <= rsp_b_d;
            rsp_err_q <= rsp_err_d;
`ifdef RFSEQ_READBACK_VERIFY_EN
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// Bench for regfile_access_sequencer: a behavioural RegisterFile model sits
// on the rf_* ports, and a shadow register array predicts every response,
// latency and RF command from the protocol rules.
module tb_regfile_access_sequencer;

    localparam int DW = 64;
    localparam int AW = 6;
    localparam int RL = 1;

    logic clk;
    logic rst_n;
    logic busy;
    logic [1:0]    rf_control_signal;
    logic [DW-1:0] rf_input_port_1, rf_input_port_2;
    logic [DW-1:0] rf_output_latch_1, rf_output_latch_2;

    regfile_access_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_access_sequencer #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(RL)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus               (bus),
        .busy              (busy),
        .rf_control_signal (rf_control_signal),
        .rf_input_port_1   (rf_input_port_1),
        .rf_input_port_2   (rf_input_port_2),
        .rf_output_latch_1 (rf_output_latch_1),
        .rf_output_latch_2 (rf_output_latch_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // RegisterFile model: writes land at the command edge; read data appears
    // RL edges after the command edge. corrupt_en flips bit 0 of a write.
    logic [DW-1:0] rf_mem   [64];
    logic [DW-1:0] ref_regs [64];
    logic [DW-1:0] pipe1 [RL];
    logic [DW-1:0] pipe2 [RL];
    bit corrupt_en;

    always @(posedge clk) begin
        if (rf_control_signal == 2'b11)
            rf_mem[rf_input_port_2[AW-1:0]] <= rf_input_port_1 ^ DW'(corrupt_en);
        for (int i = RL - 1; i > 0; i--) begin
            pipe1[i] <= pipe1[i-1];
            pipe2[i] <= pipe2[i-1];
        end
        if (rf_control_signal == 2'b01 || rf_control_signal == 2'b10)
            pipe1[0] <= rf_mem[rf_input_port_1[AW-1:0]];
        if (rf_control_signal == 2'b10)
            pipe2[0] <= rf_mem[rf_input_port_2[AW-1:0]];
    end

    assign rf_output_latch_1 = pipe1[RL-1];
    assign rf_output_latch_2 = pipe2[RL-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One complete transaction: predict, drive, observe the RF commands and
    // the response, apply `hold` cycles of backpressure, then hand it off.
    task automatic do_txn(input logic [1:0] op, input logic [AW-1:0] a,
                          input logic [AW-1:0] b, input logic [DW-1:0] wd,
                          input int hold);
        int            exp_lat, en, lat, ncmd;
        logic [DW-1:0] ea, eb;
        logic          ee;
        logic [1:0]    e_ctrl [2];
        logic [DW-1:0] e_p1 [2], e_p2 [2];
        logic [1:0]    c_ctrl [4];
        logic [DW-1:0] c_p1 [4], c_p2 [4];

        ea = '0; eb = '0; ee = 1'b0; en = 0; exp_lat = 1;
        case (op)
            2'b00: begin
                exp_lat = 1; ee = 1'b1;
            end
            2'b01: begin
                exp_lat = RL + 2; ea = ref_regs[a]; en = 1;
                e_ctrl[0] = 2'b01; e_p1[0] = 64'(a); e_p2[0] = '0;
            end
            2'b10: begin
                exp_lat = RL + 2; ea = ref_regs[a]; eb = ref_regs[b]; en = 1;
                e_ctrl[0] = 2'b10; e_p1[0] = 64'(a); e_p2[0] = 64'(b);
            end
            default: begin
                ref_regs[a] = wd ^ 64'(corrupt_en);
                en = 1;
                e_ctrl[0] = 2'b11; e_p1[0] = wd; e_p2[0] = 64'(a);
`ifdef RFSEQ_READBACK_VERIFY_EN
                exp_lat = RL + 3; ea = ref_regs[a]; ee = corrupt_en; en = 2;
                e_ctrl[1] = 2'b01; e_p1[1] = 64'(a); e_p2[1] = '0;
`else
                exp_lat = 2;
`endif
            end
        endcase

        @(negedge clk);
        check("req_ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_addr_a = a;
        bus.req_addr_b = b;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'($urandom);
        bus.req_addr_a = AW'($urandom);
        bus.req_addr_b = AW'($urandom);
        bus.req_wdata  = {$urandom, $urandom};

        lat = 0; ncmd = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (rf_control_signal != 2'b00) begin
                if (ncmd < 4) begin
                    c_ctrl[ncmd] = rf_control_signal;
                    c_p1[ncmd]   = rf_input_port_1;
                    c_p2[ncmd]   = rf_input_port_2;
                end
                ncmd++;
            end
            if (bus.rsp_valid || lat >= 40) break;
        end

        check("latency", 64'(lat), 64'(exp_lat));
        check("cmd_count", 64'(ncmd), 64'(en));
        for (int i = 0; i < en && i < ncmd; i++) begin
            check("cmd_ctrl", 64'(c_ctrl[i]), 64'(e_ctrl[i]));
            check("cmd_port1", c_p1[i], e_p1[i]);
            check("cmd_port2", c_p2[i], e_p2[i]);
        end
        check("rsp_data_a", bus.rsp_data_a, ea);
        check("rsp_data_b", bus.rsp_data_b, eb);
        check("rsp_err", 64'(bus.rsp_err), 64'(ee));
        check("req_ready_resp", 64'(bus.req_ready), 64'd0);
        check("busy_resp", 64'(busy), 64'd1);

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 64'(bus.rsp_valid), 64'd1);
            check("hold_data_a", bus.rsp_data_a, ea);
            check("hold_data_b", bus.rsp_data_b, eb);
            check("hold_err", 64'(bus.rsp_err), 64'(ee));
            check("hold_req_ready", 64'(bus.req_ready), 64'd0);
        end

        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        check("post_valid", 64'(bus.rsp_valid), 64'd0);
        check("post_req_ready", 64'(bus.req_ready), 64'd1);
        check("post_busy", 64'(busy), 64'd0);
    endtask

    // Start a single read of reg 1 and pull reset k cycles after acceptance.
    task automatic reset_mid(input int k);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_op     = 2'b01;
        bus.req_addr_a = 6'd1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (k) @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        check("mid_ctrl", 64'(rf_control_signal), (k == 1) ? 64'd1 : 64'd0);
        rst_n = 1'b0;
        #1;
        check("rst_ctrl", 64'(rf_control_signal), 64'd0);
        check("rst_port1", rf_input_port_1, 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        corrupt_en = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = 2'b00;
        bus.req_addr_a = '0; bus.req_addr_b = '0; bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            rf_mem[i]   = {$urandom, $urandom};
            ref_regs[i] = rf_mem[i];
        end
        for (int i = 0; i < RL; i++) begin
            pipe1[i] = '0;
            pipe2[i] = '0;
        end

        repeat (3) @(negedge clk);
        check("reset_req_ready", 64'(bus.req_ready), 64'd0);
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_ctrl", 64'(rf_control_signal), 64'd0);
        check("reset_port1", rf_input_port_1, 64'd0);
        check("reset_port2", rf_input_port_2, 64'd0);
        check("reset_rsp_a", bus.rsp_data_a, 64'd0);
        check("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
        rst_n = 1'b1;

        // Directed cases.
        do_txn(2'b11, 6'd1, 6'd0, 64'hDB6D_B6DB_6DB6_DB6D, 0);
        do_txn(2'b01, 6'd1, 6'd0, 64'd0, 0);
        do_txn(2'b11, 6'd2, 6'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1);
        do_txn(2'b11, 6'd3, 6'd0, 64'd7, 0);
        do_txn(2'b10, 6'd2, 6'd3, 64'd0, 5);
        do_txn(2'b00, 6'd5, 6'd6, 64'h1234, 0);
        do_txn(2'b10, 6'd63, 6'd32, 64'd0, 2);
        reset_mid(2);
        do_txn(2'b01, 6'd1, 6'd0, 64'd0, 0);
        reset_mid(1);
        do_txn(2'b01, 6'd3, 6'd0, 64'd0, 1);
`ifdef RFSEQ_READBACK_VERIFY_EN
        corrupt_en = 1'b1;
        do_txn(2'b11, 6'd10, 6'd0, 64'hA5A5_0000_FFFF_1234, 0);
        corrupt_en = 1'b0;
`endif

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
`ifdef RFSEQ_READBACK_VERIFY_EN
            corrupt_en = 1'($urandom_range(0, 1));
`endif
            do_txn(2'($urandom_range(0, 3)), AW'($urandom), AW'($urandom),
                   {$urandom, $urandom}, int'($urandom_range(0, 3)));
        end
        corrupt_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
